// File: rtl/gpio_input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gpio_input_conditioner_pkg
// Brief   : Register offsets and address-decode width for the input conditioner.
// Rev     : 1.0  initial release
// ============================================================================
package gpio_input_conditioner_pkg;

    localparam int         GPIO_COND_ADDR_W   = 3;

    localparam logic [2:0] GPIO_COND_FILT     = 3'd0;
    localparam logic [2:0] GPIO_COND_RISE_EN  = 3'd1;
    localparam logic [2:0] GPIO_COND_FALL_EN  = 3'd2;
    localparam logic [2:0] GPIO_COND_PEND     = 3'd3;
    localparam logic [2:0] GPIO_COND_LEVEL_EN = 3'd4;

endpackage
`default_nettype wire

// File: rtl/gpio_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module  : gpio_debounce_bit
// Brief   : Per-pad two-flop synchroniser, tick-based stability filter and
//           one-cycle rise/fall strobes on the filtered level.
// Rev     : 1.0  initial release
// ============================================================================
module gpio_debounce_bit
    import gpio_input_conditioner_pkg::*;
#(
    parameter int DEB_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    input  logic tick,
    output logic filt,
    output logic rise,
    output logic fall
);

    logic       r_meta;
    logic       r_sync;
    logic       r_filt;
    logic       r_filt_d;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_filt   <= 1'b0;
            r_filt_d <= 1'b0;
            r_cnt    <= 4'd0;
        end else begin
            r_meta   <= pad;
            r_sync   <= r_meta;
            r_filt_d <= r_filt;
            // Counter only moves on ticks; any agreeing sample restarts it.
            if (tick) begin
                if (r_sync != r_filt) begin
                    if (w_cnt_inc == 4'(DEB_LEN)) begin
                        r_filt <= ~r_filt;
                        r_cnt  <= 4'd0;
                    end else begin
                        r_cnt  <= w_cnt_inc;
                    end
                end else begin
                    r_cnt <= 4'd0;
                end
            end
        end
    end

    assign filt = r_filt;
    assign rise = r_filt & ~r_filt_d;
    assign fall = ~r_filt & r_filt_d;

endmodule
`default_nettype wire

// File: rtl/gpio_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : gpio_input_conditioner
// Brief   : Debounced pad inputs with edge-latched interrupts and a small
//           register file. GPIO_COND_LEVEL_IRQ_EN adds a level-interrupt enable.
// Rev     : 1.0  initial release
// ============================================================================
module gpio_input_conditioner
    import gpio_input_conditioner_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DIV     = 16,
    parameter int DEB_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] gpio_in_filt,
    output logic             irq,
    input  logic [31:0]      addr,
    input  logic [31:0]      sys_w_addr,
    input  logic [31:0]      sys_r_addr,
    input  logic [31:0]      sys_w_line,
    output logic [31:0]      sys_r_line,
    input  logic             sys_w,
    input  logic             sys_r
);

    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PRE_W-1:0] r_pre;
    logic             w_tick;
    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_wdata;
    logic [31:0]      w_rdata;
    logic [31:0]      r_rdata;
    logic             r_rvalid;
    logic             w_wsel;
    logic             w_rsel;
    logic [2:0]       w_woff;
    logic [2:0]       w_roff;
    logic             w_unused_addr;

    assign w_tick = (r_pre == PRE_W'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        gpio_debounce_bit #(.DEB_LEN(DEB_LEN)) u_deb (
            .clk  (clk),
            .rst  (rst),
            .pad  (pad_in[gi]),
            .tick (w_tick),
            .filt (w_filt[gi]),
            .rise (w_rise[gi]),
            .fall (w_fall[gi])
        );
    end

    // Base address low bits are guaranteed zero and take no part in decode.
    assign w_unused_addr = &{1'b0, addr[GPIO_COND_ADDR_W-1:0]};
    assign w_wsel  = sys_w && (sys_w_addr[31:GPIO_COND_ADDR_W] == addr[31:GPIO_COND_ADDR_W]);
    assign w_rsel  = sys_r && (sys_r_addr[31:GPIO_COND_ADDR_W] == addr[31:GPIO_COND_ADDR_W]);
    assign w_woff  = sys_w_addr[GPIO_COND_ADDR_W-1:0];
    assign w_roff  = sys_r_addr[GPIO_COND_ADDR_W-1:0];
    assign w_wdata = WIDTH'(sys_w_line);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else begin
            if (w_wsel && w_woff == GPIO_COND_RISE_EN) r_rise_en <= w_wdata;
            if (w_wsel && w_woff == GPIO_COND_FALL_EN) r_fall_en <= w_wdata;
        end
    end

`ifdef GPIO_COND_LEVEL_IRQ_EN
    logic [WIDTH-1:0] r_level_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_en <= '0;
        end else if (w_wsel && w_woff == GPIO_COND_LEVEL_EN) begin
            r_level_en <= w_wdata;
        end
    end

    assign w_level = r_level_en & w_filt;
`else
    assign w_level = '0;
`endif

    // New events override a simultaneous write-1-to-clear.
    assign w_clr = (w_wsel && w_woff == GPIO_COND_PEND) ? w_wdata : '0;
    assign w_set = (w_rise & r_rise_en) | (w_fall & r_fall_en) | w_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_roff)
            GPIO_COND_FILT:     w_rdata = 32'(w_filt);
            GPIO_COND_RISE_EN:  w_rdata = 32'(r_rise_en);
            GPIO_COND_FALL_EN:  w_rdata = 32'(r_fall_en);
            GPIO_COND_PEND:     w_rdata = 32'(r_pend);
`ifdef GPIO_COND_LEVEL_IRQ_EN
            GPIO_COND_LEVEL_EN: w_rdata = 32'(r_level_en);
`endif
            default:            w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_rsel;
            r_rdata  <= w_rsel ? w_rdata : '0;
        end
    end

    assign sys_r_line   = r_rvalid ? r_rdata : {32{1'bz}};
    assign gpio_in_filt = w_filt;
    assign irq          = |r_pend;

endmodule
`default_nettype wire

// File: tb/tb_gpio_input_conditioner.sv
`default_nettype none
// Randomised bench for gpio_input_conditioner: a rule-level reference model
// predicts filtered levels, pending bits and read data; a monitor compares.
module tb_gpio_input_conditioner;

    localparam int          WIDTH   = 32;
    localparam int          DIV     = 4;
    localparam int          DEB_LEN = 3;
    localparam logic [31:0] BASE    = 32'h0000_0100;
`ifdef GPIO_COND_LEVEL_IRQ_EN
    localparam bit LVL = 1'b1;
`else
    localparam bit LVL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pad_in = 32'h8000_0000;
    wire  [31:0] gpio_in_filt;
    wire         irq;
    logic [31:0] addr = BASE;
    logic [31:0] sys_w_addr = '0;
    logic [31:0] sys_r_addr = '0;
    logic [31:0] sys_w_line = '0;
    wire  [31:0] sys_r_line;
    logic        sys_w = 1'b0;
    logic        sys_r = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    gpio_input_conditioner #(.WIDTH(WIDTH), .DIV(DIV), .DEB_LEN(DEB_LEN)) dut (
        .clk(clk), .rst(rst), .pad_in(pad_in), .gpio_in_filt(gpio_in_filt), .irq(irq),
        .addr(addr), .sys_w_addr(sys_w_addr), .sys_r_addr(sys_r_addr),
        .sys_w_line(sys_w_line), .sys_r_line(sys_r_line), .sys_w(sys_w), .sys_r(sys_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // High-Z (or an undriven 2-state net) carries no 1 bits.
    task automatic chk_idle(input string name);
        n_checks++;
        if ($countones(sys_r_line) == 0) n_pass++;
        else $display("FAIL %s: got %h expected high-Z", name, sys_r_line);
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] v; bit idle; } rd_t;
    rd_t rd_q[$];

    logic [31:0] m_filt = '0, m_prev = '0, m_pend = '0;
    logic [31:0] m_ren = '0, m_fen = '0, m_len = '0;
    logic [31:0] m_p1 = '0, m_p2 = '0;
    int unsigned m_n = 0;
    int          m_run [WIDTH];
    logic [31:0] m_v, m_set, m_clr;
    bit          m_wm;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_filt = '0; m_prev = '0; m_pend = '0;
            m_ren = '0; m_fen = '0; m_len = '0;
            m_p1 = '0; m_p2 = '0; m_n = 0;
            for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
            rd_q.delete();
        end else begin
            if (sys_r) begin
                if (sys_r_addr[31:3] == BASE[31:3]) begin
                    case (sys_r_addr[2:0])
                        3'd0:    m_v = m_filt;
                        3'd1:    m_v = m_ren;
                        3'd2:    m_v = m_fen;
                        3'd3:    m_v = m_pend;
                        3'd4:    m_v = LVL ? m_len : 32'h0;
                        default: m_v = 32'h0;
                    endcase
                    rd_q.push_back('{v: m_v, idle: 1'b0});
                end else begin
                    rd_q.push_back('{v: 32'h0, idle: 1'b1});
                end
            end
            m_wm  = sys_w && (sys_w_addr[31:3] == BASE[31:3]);
            m_set = (m_filt & ~m_prev & m_ren) | (~m_filt & m_prev & m_fen);
            if (LVL) m_set = m_set | (m_len & m_filt);
            m_clr = (m_wm && sys_w_addr[2:0] == 3'd3) ? sys_w_line : 32'h0;
            m_pend = (m_pend & ~m_clr) | m_set;
            if (m_wm && sys_w_addr[2:0] == 3'd1) m_ren = sys_w_line;
            if (m_wm && sys_w_addr[2:0] == 3'd2) m_fen = sys_w_line;
            if (LVL && m_wm && sys_w_addr[2:0] == 3'd4) m_len = sys_w_line;
            m_prev = m_filt;
            // Every DIV-th cycle the synchronised level is sampled; DEB_LEN
            // consecutive disagreeing samples flip the filtered value.
            if ((m_n % DIV) == DIV - 1) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (m_p2[i] != m_filt[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DEB_LEN) begin
                            m_filt[i] = ~m_filt[i];
                            m_run[i]  = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            m_p2 = m_p1;
            m_p1 = pad_in;
            m_n++;
        end
    end

    // ---------------- monitor ----------------
    rd_t mon_e;
    always @(negedge clk) begin
        chk("filt", gpio_in_filt, m_filt);
        chk("irq", {31'b0, irq}, {31'b0, |m_pend});
        if (rd_q.size() > 0) begin
            mon_e = rd_q.pop_front();
            if (mon_e.idle) chk_idle("rdata_unselected");
            else            chk("rdata", sys_r_line, mon_e.v);
        end else begin
            chk_idle("rdata_idle");
        end
    end

    // ---------------- stimulus ----------------
    task automatic bus(input bit w, input logic [31:0] wa, input logic [31:0] wd,
                       input bit r, input logic [31:0] ra);
        sys_w = w; sys_w_addr = wa; sys_w_line = wd;
        sys_r = r; sys_r_addr = ra;
        @(negedge clk);
        sys_w = 1'b0; sys_r = 1'b0;
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        bus(1'b1, BASE + 32'(off), d, 1'b0, 32'h0);
    endtask

    task automatic rd(input int off);
        bus(1'b0, 32'h0, 32'h0, 1'b1, BASE + 32'(off));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_filt(input int idx, input logic val, input string name);
        int k = 0;
        while (gpio_in_filt[idx] !== val && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(name, {31'b0, gpio_in_filt[idx]}, {31'b0, val});
    endtask

    logic prev7;
    int   k7;
    int   idx;
    int   op;

    initial begin
        #23 rst = 1'b0;
        @(negedge clk);

        // Pad 31 was high through reset and must still come out as a rise.
        wait_filt(31, 1'b1, "pad_high_through_reset");

        // Same-cycle read and write of RISE_EN.
        bus(1'b1, BASE + 32'h1, 32'h0000_FFFF, 1'b1, BASE + 32'h1);
        chk("rw_old_value", sys_r_line, 32'h0);
        rd(1);
        chk("rw_new_value", sys_r_line, 32'h0000_FFFF);
        wr(1, 32'h1);
        wr(2, 32'h80);

        // Two-tick glitch on pad 0 is filtered out.
        pad_in[0] = 1'b1;
        idle(8);
        pad_in[0] = 1'b0;
        idle(20);
        chk("glitch_filtered", {31'b0, gpio_in_filt[0]}, 32'h0);
        pad_in[0] = 1'b1;
        wait_filt(0, 1'b1, "debounce_flip");
        idle(2);
        rd(3);
        chk("rise_pend", sys_r_line, 32'h1);
        chk("rise_irq", {31'b0, irq}, 32'h1);

        // Fall of bit 7 coinciding with its W1C: the set wins.
        pad_in[7] = 1'b1;
        wait_filt(7, 1'b1, "bit7_high");
        idle(2);
        wr(3, 32'hFFFF_FFFF);
        pad_in[7] = 1'b0;
        prev7 = 1'b1;
        k7 = 0;
        while (k7 < 400) begin
            if (prev7 && !gpio_in_filt[7]) break;
            prev7 = gpio_in_filt[7];
            @(negedge clk);
            k7++;
        end
        chk("bit7_fall_seen", {31'b0, gpio_in_filt[7]}, 32'h0);
        wr(3, 32'h80);
        rd(3);
        chk("race_set_wins", sys_r_line, 32'h80);

        // Decode: matching, non-matching and reserved offsets.
        bus(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0103);
        chk("decode_pend", sys_r_line, 32'h80);
        bus(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0108);
        chk_idle("decode_miss");
        wr(5, 32'hFFFF_FFFF);
        bus(1'b1, 32'h0000_0109, 32'hFFFF_FFFF, 1'b0, 32'h0);
        if (!LVL) wr(4, 32'hFFFF_FFFF);
        rd(1);
        chk("reserved_rise_en", sys_r_line, 32'h1);
        rd(2);
        chk("reserved_fall_en", sys_r_line, 32'h80);
        rd(4);
        if (!LVL) chk("offset4_zero", sys_r_line, 32'h0);
        rd(5);
        chk("offset5_zero", sys_r_line, 32'h0);

        wr(3, 32'h80);
        rd(3);
        chk("w1c_clears", sys_r_line, 32'h0);
        chk("w1c_irq_low", {31'b0, irq}, 32'h0);

`ifdef GPIO_COND_LEVEL_IRQ_EN
        wr(4, 32'h2);
        pad_in[1] = 1'b1;
        wait_filt(1, 1'b1, "level_high");
        idle(2);
        wr(3, 32'h2);
        rd(3);
        chk("level_w1c_held", sys_r_line, 32'h2);
        pad_in[1] = 1'b0;
        wait_filt(1, 1'b0, "level_low");
        idle(2);
        wr(3, 32'h2);
        rd(3);
        chk("level_w1c_clears", sys_r_line, 32'h0);
        wr(4, 32'h0);
`endif

        // Randomised traffic against the reference model.
        for (int it = 0; it < 2500; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, 31);
                pad_in[idx] = ~pad_in[idx];
            end
            op = $urandom_range(0, 9);
            case (op)
                0, 1:    wr($urandom_range(0, 7), $urandom());
                2:       rd($urandom_range(0, 7));
                3:       bus(1'b1, BASE + 32'($urandom_range(0, 7)), $urandom(),
                             1'b1, BASE + 32'($urandom_range(0, 7)));
                4:       bus(1'b1, BASE + 32'h10 + 32'($urandom_range(0, 7)), $urandom(),
                             1'b1, BASE + 32'h8 + 32'($urandom_range(0, 7)));
                default: @(negedge clk);
            endcase
        end

        // Reset while counters run and pending = 0x5.
        pad_in = '0;
        wr(1, 32'h0);
        wr(2, 32'h0);
        if (LVL) wr(4, 32'h0);
        idle(40);
        wr(3, 32'hFFFF_FFFF);
        wr(1, 32'h5);
        pad_in = 32'h5;
        idle(40);
        rd(3);
        chk("pre_reset_pend", sys_r_line, 32'h5);
        pad_in[3] = 1'b1;
        idle(5);
        sys_r = 1'b1; sys_r_addr = BASE + 32'h3;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("reset_filt", gpio_in_filt, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        chk_idle("reset_rdata");
        sys_r = 1'b0;
        idle(2);
        #3 rst = 1'b0;
        @(negedge clk);
        rd(3);
        chk("post_reset_pend", sys_r_line, 32'h0);
        rd(1);
        chk("post_reset_rise_en", sys_r_line, 32'h0);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
